// File: rtl/clk_wiz_div_model.sv
// Synthesizable stand-in for a clock-wizard core: dac_clk divider, lock timer and input-clock-stop monitor.
// Optional macro CLK_FWD_EN enables the forwarded-clock flop on clk_fwd; without it clk_fwd is tied low.
`timescale 1ns/1ps
module clk_wiz_div_model #(
  parameter int HALF_DIV     = 2,
  parameter int LOCK_CYCLES  = 100,
  parameter int STOP_TIMEOUT = 16
) (
  input  logic dac_clk,
  input  logic reset,
  input  logic mon_clk,
  input  logic power_down,
  output logic clk_out1,
  output logic clk_fwd,
  output logic locked,
  output logic input_clk_stopped
);
  localparam logic [15:0] DIV_LAST  = 16'(HALF_DIV - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] STOP_LIM  = 16'(STOP_TIMEOUT);

  typedef enum logic [1:0] {UNLOCKED, COUNTING, LOCKED} lock_state_t;

  logic [15:0] div_cnt;
  logic        clk_out1_reg;
  lock_state_t lock_state;
  logic [15:0] lock_cnt;
  logic        lock_reg;
  logic [1:0]  stop_sync_reg;
  logic        stop_sync;
  logic        tog_reg;
  logic [2:0]  tog_sync_reg;
  logic        tog_edge;
  logic [15:0] idle_cnt;
  logic [15:0] idle_next;
  logic        stopped_reg;

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      clk_out1_reg <= 1'b0;
    end else if (power_down) begin
      div_cnt      <= '0;
      clk_out1_reg <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt      <= '0;
      clk_out1_reg <= ~clk_out1_reg;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  // The first edge out of UNLOCKED already counts, so lock_reg rises on edge LOCK_CYCLES.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      lock_state <= UNLOCKED;
      lock_cnt   <= '0;
      lock_reg   <= 1'b0;
    end else if (power_down || stop_sync) begin
      lock_state <= UNLOCKED;
      lock_cnt   <= '0;
      lock_reg   <= 1'b0;
    end else begin
      case (lock_state)
        UNLOCKED, COUNTING: begin
          if (lock_cnt == LOCK_LAST) begin
            lock_state <= LOCKED;
            lock_reg   <= 1'b1;
          end else begin
            lock_state <= COUNTING;
            lock_cnt   <= lock_cnt + 16'd1;
          end
        end
        LOCKED:  lock_reg <= 1'b1;
        default: begin
          lock_state <= UNLOCKED;
          lock_cnt   <= '0;
          lock_reg   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      stop_sync_reg <= '0;
      tog_reg       <= 1'b0;
    end else begin
      stop_sync_reg <= {stop_sync_reg[0], stopped_reg};
      tog_reg       <= ~tog_reg;
    end
  end

  assign stop_sync = stop_sync_reg[1];

  // Monitor side: any change of the toggle flop proves dac_clk is alive.
  assign tog_edge = tog_sync_reg[2] ^ tog_sync_reg[1];

  always_comb begin
    idle_next = idle_cnt;
    if (tog_edge)
      idle_next = '0;
    else if (idle_cnt != 16'hFFFF)
      idle_next = idle_cnt + 16'd1;
  end

  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      tog_sync_reg <= '0;
      idle_cnt     <= '0;
      stopped_reg  <= 1'b0;
    end else begin
      tog_sync_reg <= {tog_sync_reg[1:0], tog_reg};
      idle_cnt     <= idle_next;
      stopped_reg  <= (idle_next >= STOP_LIM);
    end
  end

`ifdef CLK_FWD_EN
  logic fwd_reg;

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset)
      fwd_reg <= 1'b0;
    else
      fwd_reg <= clk_out1_reg;
  end

  assign clk_fwd = fwd_reg & lock_reg;
`else
  assign clk_fwd = 1'b0;
`endif

  assign clk_out1          = clk_out1_reg;
  assign locked            = lock_reg & ~stopped_reg;
  assign input_clk_stopped = stopped_reg;
endmodule

// File: tb/tb_clk_wiz_div_model.sv
// Scoreboard bench for clk_wiz_div_model: default instance plus a HALF_DIV=1/LOCK_CYCLES=1 instance.
`timescale 1ns/1ps
module tb_clk_wiz_div_model;
`ifdef CLK_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic dac_clk = 1'b0;
  logic mon_clk = 1'b0;
  logic reset = 1'b1;
  logic power_down = 1'b0;
  logic dac_run = 1'b1;
  logic clk_out1, clk_fwd, locked, input_clk_stopped;
  logic clk_out1_b, clk_fwd_b, locked_b, stopped_b;
  logic [3:0] st, st_b;
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int dac_edges = 0;

  always #5 if (dac_run) dac_clk = ~dac_clk;
  always #4 mon_clk = ~mon_clk;
  always @(posedge dac_clk) dac_edges <= dac_edges + 1;

  assign st   = {clk_out1, clk_fwd, locked, input_clk_stopped};
  assign st_b = {clk_out1_b, clk_fwd_b, locked_b, stopped_b};

  clk_wiz_div_model dut (
    .dac_clk(dac_clk), .reset(reset), .mon_clk(mon_clk), .power_down(power_down),
    .clk_out1(clk_out1), .clk_fwd(clk_fwd), .locked(locked), .input_clk_stopped(input_clk_stopped)
  );

  clk_wiz_div_model #(.HALF_DIV(1), .LOCK_CYCLES(1), .STOP_TIMEOUT(16)) dut_min (
    .dac_clk(dac_clk), .reset(reset), .mon_clk(mon_clk), .power_down(power_down),
    .clk_out1(clk_out1_b), .clk_fwd(clk_fwd_b), .locked(locked_b), .input_clk_stopped(stopped_b)
  );

  // Expected status word {clk_out1, clk_fwd, locked, input_clk_stopped}.
  function automatic logic [31:0] pack(bit co, bit fwd, bit lk, bit stp);
    return {28'd0, co, fwd, lk, stp};
  endfunction

  task automatic test_reset();
    logic [31:0] e;
    reset = 1'b1;
    repeat (3) @(negedge dac_clk);
    exp_q.push_back(pack(0, 0, 0, 0));
    exp_q.push_back(pack(0, 0, 0, 0));
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st) !== e) begin n_bad++; $display("FAIL reset_state dut got %b want %b", st, e[3:0]); end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st_b) !== e) begin n_bad++; $display("FAIL reset_state dut_min got %b want %b", st_b, e[3:0]); end
  endtask

  task automatic test_lock_divide();
    logic [31:0] e;
    @(negedge dac_clk);
    reset = 1'b0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge dac_clk);
      exp_q.push_back(pack(((n / 2) % 2) == 1, FWD_EN && n >= 100 && (((n - 1) / 2) % 2) == 1, n >= 100, 0));
      exp_q.push_back(pack((n % 2) == 1, FWD_EN && ((n - 1) % 2) == 1, 1, 0));
      @(negedge dac_clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (32'(st) !== e) begin n_bad++; $display("FAIL lock_divide edge=%0d dut got %b want %b", n, st, e[3:0]); end
      e = exp_q.pop_front();
      n_cmp++;
      if (32'(st_b) !== e) begin n_bad++; $display("FAIL lock_divide edge=%0d dut_min got %b want %b", n, st_b, e[3:0]); end
    end
  endtask

  task automatic test_power_down();
    logic [31:0] e;
    int snap;
    @(negedge dac_clk);
    power_down = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge dac_clk);
      exp_q.push_back(pack(0, 0, 0, 0));
      exp_q.push_back(pack(0, 0, 0, 0));
      @(negedge dac_clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (32'(st) !== e) begin n_bad++; $display("FAIL power_down hold=%0d dut got %b want %b", k, st, e[3:0]); end
      e = exp_q.pop_front();
      n_cmp++;
      if (32'(st_b) !== e) begin n_bad++; $display("FAIL power_down hold=%0d dut_min got %b want %b", k, st_b, e[3:0]); end
    end
    power_down = 1'b0;
    for (int m = 1; m <= 99; m++) begin
      @(posedge dac_clk);
      exp_q.push_back(pack(((m / 2) % 2) == 1, 0, 0, 0));
      exp_q.push_back(pack((m % 2) == 1, FWD_EN && ((m - 1) % 2) == 1, 1, 0));
      @(negedge dac_clk);
      e = exp_q.pop_front();
      n_cmp++;
      if (32'(st) !== e) begin n_bad++; $display("FAIL pd_relock edge=%0d dut got %b want %b", m, st, e[3:0]); end
      e = exp_q.pop_front();
      n_cmp++;
      if (32'(st_b) !== e) begin n_bad++; $display("FAIL pd_relock edge=%0d dut_min got %b want %b", m, st_b, e[3:0]); end
    end
    // power_down lands on the edge that would complete the lock
    power_down = 1'b1;
    @(posedge dac_clk);
    exp_q.push_back(pack(0, 0, 0, 0));
    @(negedge dac_clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st) !== e) begin n_bad++; $display("FAIL pd_vs_lock dut got %b want %b", st, e[3:0]); end
    power_down = 1'b0;
    snap = dac_edges;
    exp_q.push_back(32'd100);
    for (int i = 0; i < 150 && locked !== 1'b1; i++) @(negedge dac_clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(dac_edges - snap) !== e) begin n_bad++; $display("FAIL pd_relock_edges got %0d want %0d", dac_edges - snap, e); end
  endtask

  task automatic test_clock_stop();
    logic [31:0] e;
    int cnt;
    int snap;
    @(negedge dac_clk);
    dac_run = 1'b0;
    exp_q.push_back(32'd1);
    cnt = 0;
    while (input_clk_stopped !== 1'b1 && cnt < 40) begin @(posedge mon_clk); #1; cnt++; end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(cnt >= 14 && cnt <= 20) !== e) begin n_bad++; $display("FAIL stop_detect mon_cycles got %0d want 14..20", cnt); end
    exp_q.push_back(32'b001);
    e = exp_q.pop_front();
    n_cmp++;
    if (32'({locked, locked_b, stopped_b}) !== e) begin
      n_bad++; $display("FAIL stop_lock_drop {locked,locked_b,stopped_b} got %b want %b", {locked, locked_b, stopped_b}, e[2:0]);
    end
    dac_run = 1'b1;
    snap = dac_edges;
    exp_q.push_back(32'd1);
    cnt = 0;
    while (input_clk_stopped !== 1'b0 && cnt < 20) begin @(posedge mon_clk); #1; cnt++; end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(cnt <= 4) !== e) begin n_bad++; $display("FAIL stop_clear mon_cycles got %0d want <=4", cnt); end
    exp_q.push_back(32'd1);
    for (int i = 0; i < 200; i++) begin @(negedge dac_clk); if (locked === 1'b1) break; end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'((dac_edges - snap) >= 100 && (dac_edges - snap) <= 110) !== e) begin
      n_bad++; $display("FAIL stop_relock_edges got %0d want 100..110", dac_edges - snap);
    end
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(locked_b) !== e) begin n_bad++; $display("FAIL stop_relock dut_min locked got %b want 1", locked_b); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    @(negedge dac_clk);
    reset = 1'b1;
    @(negedge dac_clk);
    reset = 1'b0;
    repeat (50) @(posedge dac_clk);
    @(negedge dac_clk);
    exp_q.push_back(pack(1, 0, 0, 0));
    exp_q.push_back(pack(0, FWD_EN, 1, 0));
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st) !== e) begin n_bad++; $display("FAIL pre_reset dut got %b want %b", st, e[3:0]); end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st_b) !== e) begin n_bad++; $display("FAIL pre_reset dut_min got %b want %b", st_b, e[3:0]); end
    #2 reset = 1'b1;
    exp_q.push_back(pack(0, 0, 0, 0));
    exp_q.push_back(pack(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st) !== e) begin n_bad++; $display("FAIL async_reset dut got %b want %b", st, e[3:0]); end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st_b) !== e) begin n_bad++; $display("FAIL async_reset dut_min got %b want %b", st_b, e[3:0]); end
  endtask

  task automatic test_reset_dead_clock();
    logic [31:0] e;
    int snap;
    int cnt;
    @(negedge dac_clk);
    reset = 1'b0;
    repeat (3) @(negedge dac_clk);
    dac_run = 1'b0;
    exp_q.push_back(32'd1);
    cnt = 0;
    while (input_clk_stopped !== 1'b1 && cnt < 40) begin @(posedge mon_clk); #1; cnt++; end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(input_clk_stopped) !== e) begin n_bad++; $display("FAIL dead_clk_stopped got %b want 1", input_clk_stopped); end
    @(negedge mon_clk);
    #1 reset = 1'b1;
    exp_q.push_back(pack(0, 0, 0, 0));
    exp_q.push_back(pack(0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st) !== e) begin n_bad++; $display("FAIL dead_clk_reset dut got %b want %b", st, e[3:0]); end
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(st_b) !== e) begin n_bad++; $display("FAIL dead_clk_reset dut_min got %b want %b", st_b, e[3:0]); end
    dac_run = 1'b1;
    repeat (3) @(negedge dac_clk);
    reset = 1'b0;
    snap = dac_edges;
    exp_q.push_back(32'd100);
    for (int i = 0; i < 150 && locked !== 1'b1; i++) @(negedge dac_clk);
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(dac_edges - snap) !== e) begin n_bad++; $display("FAIL reset_relock_edges got %0d want %0d", dac_edges - snap, e); end
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    n_cmp++;
    if (32'(locked_b) !== e) begin n_bad++; $display("FAIL reset_relock dut_min locked got %b want 1", locked_b); end
  endtask

  initial begin
    test_reset();
    test_lock_divide();
    test_power_down();
    test_clock_stop();
    test_reset_mid();
    test_reset_dead_clock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
